// File: rtl/jvm_insn_assembler_if.sv
// Bytecode stream in, ROM lookup, and assembled-instruction out for jvm_insn_assembler.
// The slave side is the assembler; the master side is the fetch/ROM/translator environment.
interface jvm_insn_assembler_if #(
    parameter int MAX_OPS = 16,
    parameter int PC_W    = 16
);
    logic [7:0]           in_byte;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           lk_opcode;
    logic [4:0]           lk_count;
    logic                 flush;
    logic [PC_W-1:0]      flush_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_opcode;
    logic [8*MAX_OPS-1:0] out_operands;
    logic [4:0]           out_count;
    logic [PC_W-1:0]      out_pc;
    logic                 out_err;

    modport master (
        output in_byte, in_valid, lk_count, flush, flush_pc, out_ready,
        input  in_ready, lk_opcode, out_valid, out_opcode, out_operands,
               out_count, out_pc, out_err
    );

    modport slave (
        input  in_byte, in_valid, lk_count, flush, flush_pc, out_ready,
        output in_ready, lk_opcode, out_valid, out_opcode, out_operands,
               out_count, out_pc, out_err
    );
endinterface

// File: rtl/jvm_insn_assembler.sv
// Groups the raw JVM bytecode stream into opcode + operand-byte instructions,
// using the external operand-count ROM to know how many bytes follow each opcode.
module jvm_insn_assembler #(
    parameter int MAX_OPS = 16,
    parameter int PC_W    = 16
) (
    input logic clk,
    input logic rst,
    jvm_insn_assembler_if.slave bus
);
    typedef enum logic [1:0] {OPCODE, OPERANDS, HOLD} state_t;

    localparam logic [4:0] MAX_CNT = 5'(MAX_OPS);

    state_t                  state;
    logic [PC_W-1:0]         pc;
    logic [4:0]              idx;
    logic [4:0]              remaining;
    logic [MAX_OPS-1:0][7:0] ops;
    logic                    valid;
    logic [7:0]              opcode;
    logic [4:0]              count;
    logic [PC_W-1:0]         insn_pc;
    logic                    err;
    logic                    accept;

    assign bus.lk_opcode    = bus.in_byte;
    assign bus.in_ready     = (state != HOLD) && !bus.flush;
    assign accept           = bus.in_valid && bus.in_ready;
    assign bus.out_valid    = valid;
    assign bus.out_opcode   = opcode;
    assign bus.out_operands = ops;
    assign bus.out_count    = count;
    assign bus.out_pc       = insn_pc;
    assign bus.out_err      = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OPCODE;
            pc        <= '0;
            idx       <= '0;
            remaining <= '0;
            ops       <= '0;
            valid     <= 1'b0;
            opcode    <= '0;
            count     <= '0;
            insn_pc   <= '0;
            err       <= 1'b0;
        end else if (bus.flush) begin
            // Instruction fields are left as-is; they are meaningless once valid drops.
            state <= OPCODE;
            valid <= 1'b0;
            pc    <= bus.flush_pc;
        end else begin
            case (state)
                OPCODE: if (accept) begin
                    pc        <= pc + 1'b1;
                    opcode    <= bus.in_byte;
                    insn_pc   <= pc;
                    count     <= bus.lk_count;
                    ops       <= '0;
                    idx       <= '0;
                    err       <= bus.lk_count > MAX_CNT;
                    remaining <= bus.lk_count;
                    if (bus.lk_count == 5'd0) begin
                        state <= HOLD;
                        valid <= 1'b1;
                    end else begin
                        state <= OPERANDS;
                    end
                end
                OPERANDS: if (accept) begin
                    pc <= pc + 1'b1;
                    // Bytes past MAX_OPS match no slot: consumed but not stored.
                    for (int k = 0; k < MAX_OPS; k++)
                        if (idx == 5'(k)) ops[k] <= bus.in_byte;
                    idx       <= idx + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == 5'd1) begin
                        state <= HOLD;
                        valid <= 1'b1;
                    end
                end
                HOLD: if (bus.out_ready) begin
                    state <= OPCODE;
                    valid <= 1'b0;
                end
                default: state <= OPCODE;
            endcase
        end
    end
endmodule
